serial_adder: RTL

//   Bit-serial WIDTH-bit adder built around one full_adder instance.

---
 rtl/serial_adder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell is reused LSB-first, with the
// running carry held in a register, behind valid/ready handshakes on both sides.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WIDTH-1:0]  a_sh_r;
  logic [WIDTH-1:0]  b_sh_r;
  logic [WIDTH-1:0]  sum_sh_r;
  logic              carry_r;
  logic [CNT_W-1:0]  count_r;
  logic              fa_sum_s;
  logic              fa_cout_s;

  full_adder u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_sum_s),
    .cout (fa_cout_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: if (in_valid) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      RUN:  if (count_r == LAST_BIT) state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE: if (out_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry and bit counter
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a_in;
            b_sh_r  <= b_in;
            carry_r <= cin;
            count_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so bit 0 lands at sum_sh_r[0] after WIDTH shifts.
          sum_sh_r <= {fa_sum_s, sum_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= fa_cout_s;
          count_r  <= count_r + CNT_W'(1);
        end
        DONE: begin
          carry_r <= carry_r;
        end
        default: begin
          count_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Handshake and result outputs decoded from the state register only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum_out   = {WIDTH{1'b0}};
    cout_out  = 1'b0;
    if (state_r == DONE) begin
      out_valid = 1'b1;
      sum_out   = sum_sh_r;
      cout_out  = carry_r;
    end else begin
      in_ready = (state_r == IDLE);
    end
  end

endmodule
